// File: rtl/wdata_fifo_arb_if.sv
// Write-data bus between two requesters, the arbiter and the write-data FIFO.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface wdata_fifo_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s0_wvalid;
    logic [DATA_WIDTH-1:0] s0_wdata;
    logic                  s0_wlast;
    logic                  s0_wready;
    logic                  s1_wvalid;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic                  s1_wlast;
    logic                  s1_wready;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [DATA_WIDTH-1:0] fifo_data_in;

    modport slave (
        input  s0_wvalid, s0_wdata, s0_wlast,
        input  s1_wvalid, s1_wdata, s1_wlast,
        input  fifo_full,
        output s0_wready, s1_wready, fifo_wr, fifo_data_in
    );

    modport master (
        output s0_wvalid, s0_wdata, s0_wlast,
        output s1_wvalid, s1_wdata, s1_wlast,
        output fifo_full,
        input  s0_wready, s1_wready, fifo_wr, fifo_data_in
    );
endinterface

// File: rtl/wdata_fifo_arb.sv
// Two-requester round-robin write-data arbiter feeding a FIFO with zero-latency
// pass-through; grants are held for a whole burst, bounded to MAX_BEATS beats.
module wdata_fifo_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    wdata_fifo_arb_if.slave  bus,
    input  logic             err_clr,
    output logic             gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err_overlen
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

    state_t                state;
    logic                  last_gnt;
    logic                  sel_last;
    logic                  other_valid;
    logic                  accept;
    logic                  term;

    // Steer the granted requester onto the FIFO port; everything is 0 in IDLE.
    always_comb begin
        bus.s0_wready    = 1'b0;
        bus.s1_wready    = 1'b0;
        bus.fifo_wr      = 1'b0;
        bus.fifo_data_in = '0;
        sel_last         = 1'b0;
        other_valid      = 1'b0;
        case (state)
            GNT0: begin
                bus.s0_wready    = ~bus.fifo_full;
                bus.fifo_wr      = bus.s0_wvalid & ~bus.fifo_full;
                bus.fifo_data_in = bus.s0_wdata;
                sel_last         = bus.s0_wlast;
                other_valid      = bus.s1_wvalid;
            end
            GNT1: begin
                bus.s1_wready    = ~bus.fifo_full;
                bus.fifo_wr      = bus.s1_wvalid & ~bus.fifo_full;
                bus.fifo_data_in = bus.s1_wdata;
                sel_last         = bus.s1_wlast;
                other_valid      = bus.s0_wvalid;
            end
            default: begin
                sel_last    = 1'b0;
                other_valid = 1'b0;
            end
        endcase
    end

    assign accept = bus.fifo_wr;
    assign term   = sel_last | (beat_cnt == LAST_IDX);
    assign gnt_id = last_gnt;

    // Arbitration FSM, burst beat counter and sticky over-length flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            busy        <= 1'b0;
            beat_cnt    <= '0;
            err_overlen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s0_wvalid && (!bus.s1_wvalid || last_gnt)) begin
                        state    <= GNT0;
                        last_gnt <= 1'b0;
                        busy     <= 1'b1;
                    end else if (bus.s1_wvalid) begin
                        state    <= GNT1;
                        last_gnt <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GNT0, GNT1: begin
                    if (accept && term) begin
                        beat_cnt <= '0;
                        // Hand straight to the waiting requester: no idle bubble.
                        if (other_valid) begin
                            state    <= (state == GNT0) ? GNT1 : GNT0;
                            last_gnt <= (state == GNT0) ? 1'b1 : 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end else begin
                        beat_cnt <= beat_cnt;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    beat_cnt <= '0;
                end
            endcase

            // A forced termination outranks a simultaneous clear.
            if (accept && term && !sel_last) begin
                err_overlen <= 1'b1;
            end else if (err_clr) begin
                err_overlen <= 1'b0;
            end else begin
                err_overlen <= err_overlen;
            end
        end
    end
endmodule

// File: tb/tb_wdata_fifo_arb.sv
// Scoreboard bench for wdata_fifo_arb: requester beat queues drive the bus and
// every FIFO write is popped against the expected-data queue.
module tb_wdata_fifo_arb;
    logic        clk;
    logic        rst;
    logic        err_clr;
    logic        gnt_id;
    logic        busy;
    logic [4:0]  beat_cnt;
    logic        err_overlen;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          first_wr;
    int          last_wr;

    logic [31:0] exp_q[$];
    logic [31:0] q0_d[$];
    bit          q0_l[$];
    logic [31:0] q1_d[$];
    bit          q1_l[$];

    wdata_fifo_arb_if #(.DATA_WIDTH(32)) bus ();

    wdata_fifo_arb #(
        .DATA_WIDTH(32),
        .MAX_BEATS (16),
        .CNT_W     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
        .err_overlen(err_overlen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void drive();
        bus.s0_wvalid = (q0_d.size() != 0);
        bus.s0_wdata  = (q0_d.size() != 0) ? q0_d[0] : 32'd0;
        bus.s0_wlast  = (q0_l.size() != 0) ? q0_l[0] : 1'b0;
        bus.s1_wvalid = (q1_d.size() != 0);
        bus.s1_wdata  = (q1_d.size() != 0) ? q1_d[0] : 32'd0;
        bus.s1_wlast  = (q1_l.size() != 0) ? q1_l[0] : 1'b0;
    endfunction

    task automatic load(input int who, input logic [31:0] base, input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            if (who == 0) begin
                q0_d.push_back(base + 32'(i));
                q0_l.push_back(use_last && (i == n - 1));
            end else begin
                q1_d.push_back(base + 32'(i));
                q1_l.push_back(use_last && (i == n - 1));
            end
            exp_q.push_back(base + 32'(i));
        end
        drive();
    endtask

    // One clock: sample on negedge, retire accepted beats just after posedge.
    task automatic step(input logic full);
        logic acc0;
        logic acc1;
        bus.fifo_full = full;
        @(negedge clk);
        cyc++;
        acc0 = bus.s0_wvalid & bus.s0_wready;
        acc1 = bus.s1_wvalid & bus.s1_wready;
        check_val("wready_excl", {31'd0, bus.s0_wready & bus.s1_wready}, 32'd0);
        if (full) begin
            check_val("full_wready", {31'd0, bus.s0_wready | bus.s1_wready}, 32'd0);
            check_val("full_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
        end
        if (bus.fifo_wr) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            check_val("sb_avail", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_val("fifo_data", bus.fifo_data_in, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (acc0) begin
            void'(q0_d.pop_front());
            void'(q0_l.pop_front());
        end
        if (acc1) begin
            void'(q1_d.pop_front());
            void'(q1_l.pop_front());
        end
        drive();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q0_d.size() != 0 || q1_d.size() != 0 || busy); i++) step(1'b0);
        check_val("drain_done", {31'd0, (q0_d.size() != 0) | (q1_d.size() != 0) | busy}, 32'd0);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        cyc           = 0;
        first_wr      = -1;
        last_wr       = -1;
        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.fifo_full = 1'b0;
        drive();
        #2;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_gnt_id", {31'd0, gnt_id}, 32'd1);
        check_val("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check_val("rst_err", {31'd0, err_overlen}, 32'd0);
        check_val("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
        check_val("rst_data", bus.fifo_data_in, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Tie after reset: s0 first, then s1 with no bubble.
        load(0, 32'hA000_0000, 4, 1'b1);
        load(1, 32'hB000_0000, 4, 1'b1);
        drain();
        check_val("tie_no_bubble", 32'(last_wr - first_wr), 32'd7);
        check_val("tie_gnt_id", {31'd0, gnt_id}, 32'd1);

        // Backpressure mid-burst on s0.
        load(0, 32'hC000_0000, 4, 1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_val("bp_cnt_before", 32'(beat_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_val("bp_cnt_held", 32'(beat_cnt), 32'd2);
            check_val("bp_busy", {31'd0, busy}, 32'd1);
        end
        drain();
        check_val("bp_gnt_id", {31'd0, gnt_id}, 32'd0);

        // Over-length: 17 beats from s1, no wlast.
        load(1, 32'hD000_0000, 17, 1'b0);
        for (int i = 0; i < 40 && q1_d.size() > 1; i++) step(1'b0);
        check_val("ovl_err_set", {31'd0, err_overlen}, 32'd1);
        check_val("ovl_cnt_zero", 32'(beat_cnt), 32'd0);
        check_val("ovl_idle", {31'd0, busy}, 32'd0);
        step(1'b0);
        step(1'b0);
        check_val("ovl_regrant", {31'd0, busy}, 32'd1);
        check_val("ovl_regrant_id", {31'd0, gnt_id}, 32'd1);
        check_val("ovl_beat17_cnt", 32'(beat_cnt), 32'd1);

        // err_clr without a set event clears the flag.
        err_clr = 1'b1;
        step(1'b0);
        err_clr = 1'b0;
        check_val("clr_alone", {31'd0, err_overlen}, 32'd0);

        // err_clr coincident with a forced termination: set wins.
        load(1, 32'hE000_0000, 15, 1'b0);
        for (int i = 0; i < 40 && q1_d.size() > 1; i++) step(1'b0);
        check_val("clr_pre_cnt", 32'(beat_cnt), 32'd15);
        err_clr = 1'b1;
        step(1'b0);
        err_clr = 1'b0;
        check_val("clr_vs_set", {31'd0, err_overlen}, 32'd1);
        check_val("clr_vs_set_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset at beat 2 of an s0 burst.
        load(0, 32'hF000_0000, 4, 1'b1);
        step(1'b0);
        step(1'b0);
        check_val("mid_cnt", 32'(beat_cnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_cnt", 32'(beat_cnt), 32'd0);
        check_val("arst_err", {31'd0, err_overlen}, 32'd0);
        check_val("arst_gnt_id", {31'd0, gnt_id}, 32'd1);
        check_val("arst_wready", {31'd0, bus.s0_wready | bus.s1_wready}, 32'd0);
        check_val("arst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
        check_val("arst_data", bus.fifo_data_in, 32'd0);
        q0_d.delete();
        q0_l.delete();
        exp_q.delete();
        load(0, 32'h1111_0000, 1, 1'b1);
        load(1, 32'h2222_0000, 1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rel_no_grant", {31'd0, busy}, 32'd0);
        step(1'b0);
        check_val("rel_gnt0", {31'd0, gnt_id}, 32'd0);
        check_val("rel_busy", {31'd0, busy}, 32'd1);
        drain();

        // Single requester s1 with back-to-back 1-beat bursts.
        load(1, 32'h3333_0000, 1, 1'b1);
        load(1, 32'h3333_0010, 1, 1'b1);
        load(1, 32'h3333_0020, 1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            check_val("single_busy", {31'd0, busy}, {31'd0, ~i[0]});
            check_val("single_s0_rdy", {31'd0, bus.s0_wready}, 32'd0);
        end
        check_val("single_gnt_id", {31'd0, gnt_id}, 32'd1);
        check_val("single_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wdata_fifo_arb.md
WDATA_FIFO_ARB -- requirements
Module: wdata_fifo_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the write-data beat and the FIFO data port.
REQ-002 SHALL have parameter MAX_BEATS, default 16, maximum legal beats per burst.
REQ-003 SHALL have parameter CNT_W, default 5, width of the beat counter; CNT_W SHALL satisfy 2**CNT_W > MAX_BEATS.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Ports s0_wvalid / s1_wvalid  in  1  requester 0/1 beat valid.
REQ-008 Ports s0_wdata / s1_wdata  in  DATA_WIDTH  requester 0/1 beat data.
REQ-009 Ports s0_wlast / s1_wlast  in  1  requester 0/1 last beat of burst.
REQ-010 Ports s0_wready / s1_wready  out  1  requester 0/1 beat accepted when valid and ready are both high.
REQ-011 Port fifo_full  in  1  full flag of the write-data FIFO.
REQ-012 Port fifo_wr  out  1  FIFO write strobe.
REQ-013 Port fifo_data_in  out  DATA_WIDTH  FIFO write data.
REQ-014 Port err_clr  in  1  clears err_overlen.
REQ-015 Port gnt_id  out  1  currently or last granted requester.
REQ-016 Port busy  out  1  high while a burst is granted.
REQ-017 Port beat_cnt  out  CNT_W  beats accepted in the current burst.
REQ-018 Port err_overlen  out  1  sticky over-length burst flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, GNT0, GNT1; busy SHALL be high in GNT0 and GNT1.
REQ-020 In IDLE with exactly one wvalid high, the next state SHALL be GNT of that requester.
REQ-021 In IDLE with both wvalid high, the next state SHALL be GNT of the requester not equal to last_gnt (round robin).
REQ-022 last_gnt SHALL update on entry to GNTx; gnt_id SHALL equal last_gnt.
REQ-023 In IDLE, both wready outputs and fifo_wr SHALL be 0, and fifo_data_in SHALL be 0.
REQ-024 In GNTx, sx_wready SHALL equal ~fifo_full, and the other requester's wready SHALL be 0.
REQ-025 In GNTx, fifo_data_in SHALL equal sx_wdata (combinational).
REQ-026 In GNTx, fifo_wr SHALL equal sx_wvalid & ~fifo_full; the beat is accepted in the same cycle, with zero latency to the FIFO.
REQ-027 With fifo_full high, no beat SHALL be accepted, and the state and beat_cnt SHALL hold.
REQ-028 beat_cnt SHALL increment on each accepted non-terminating beat and return to 0 on the terminating beat.
REQ-029 A beat SHALL be terminating if sx_wlast=1 or beat_cnt == MAX_BEATS-1.
REQ-030 On a terminating beat with sx_wlast=0, err_overlen SHALL set on the next edge and remain set until err_clr.
REQ-031 When err_clr is asserted in the same cycle as a set event, the set SHALL win.
REQ-032 On a terminating beat, the next state SHALL be GNT of the other requester if its wvalid is high, else IDLE; there is no bubble on hand-off.
REQ-033 A grant SHALL NOT be revoked mid-burst; sx_wvalid dropping mid-burst SHALL hold GNTx.
REQ-034 beat_cnt SHALL never wrap; the terminating rule bounds it to MAX_BEATS-1.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE, last_gnt=1, gnt_id=1, beat_cnt=0, err_overlen=0, busy=0, s0_wready=0, s1_wready=0, fifo_wr=0, fifo_data_in=0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from IDLE with requester 0 winning the first tie.
REQ-037 Deassertion SHALL be sampled on clk; the first grant SHALL occur no earlier than the first edge after release.

Verification
REQ-038 Tie after reset: s0_wvalid=s1_wvalid=1, 4-beat bursts each with wlast on beat 4 -> GNT0 for 4 fifo_wr, then GNT1 for 4 fifo_wr with no idle cycle, then IDLE, gnt_id=1.
REQ-039 Backpressure: in GNT0, fifo_full=1 for 3 cycles mid-burst -> s0_wready=0, fifo_wr=0, beat_cnt held, no data lost; all 4 data words reach the FIFO in order.
REQ-040 Over-length: s1 sends 17 beats, wlast never set, MAX_BEATS=16 -> burst terminates at beat 16, err_overlen=1, beat_cnt=0; beat 17 starts a new grant.
REQ-041 err_clr pulse with no set event -> err_overlen=0 next cycle; err_clr coincident with a set event -> err_overlen stays 1.
REQ-042 Reset mid-burst: rst=1 asynchronously at beat 2 of an s0 burst -> all outputs reach reset values without a clock edge; after release with both valid, GNT0 is granted first.
REQ-043 Single requester: s1 only, 1-beat bursts back to back -> GNT1, IDLE, GNT1 alternating; s0_wready=0 throughout.
